// File: rtl/key_scan_if.sv
// Keypad scanner port bundle: row inputs from the matrix, column strobes and key reports out.
// master = scanner, slave = keypad matrix plus the key consumer.
interface key_scan_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: one-hot column strobes, whole-keypad frame debounce,
// and a single report per press (key_code + one-cycle key_valid).
module key_scan #(
  parameter int SCAN_DIV     = 200000,
  parameter int DEBOUNCE_CNT = 4
) (
  input logic        clk,
  input logic        reset,
  key_scan_if.master kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    BLOCKED
  } state_t;

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [3:0]       col;
  logic [1:0]       col_idx;
  logic [3:0]       row_meta;
  logic [3:0]       row_s;
  logic [15:0]      work_frame;
  logic [15:0]      sample_frame;
  logic [15:0]      last_frame;
  logic [CNT_W-1:0] stable_cnt;
  logic             frame_close;
  logic             frame_same;
  logic             frame_zero;
  logic             one_key;
  logic             multi_key;
  logic             accept;
  logic [3:0]       key_index;
  state_t           state;
  logic [3:0]       key_code;
  logic             key_valid;
  logic             key_held;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col     <= 4'b0001;
      col_idx <= 2'd0;
    end else if (tick) begin
      col     <= {col[2:0], col[3]};
      col_idx <= col_idx + 2'd1;
    end
  end

  // Rows are asynchronous to clk; two flops before any use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta <= '0;
      row_s    <= '0;
    end else begin
      row_meta <= kp.row;
      row_s    <= row_meta;
    end
  end

  // Working frame with the current column's slice replaced by this tick's sample,
  // so the column-3 sample is part of the frame compared on the closing tick.
  always_comb begin
    sample_frame = work_frame;
    for (int r = 0; r < 4; r++) begin
      sample_frame[4*r + int'(col_idx)] = row_s[r];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_frame <= '0;
    end else if (tick) begin
      work_frame <= sample_frame;
    end
  end

  assign frame_close = tick && (col_idx == 2'd3);
  assign frame_same  = (sample_frame == last_frame);
  assign frame_zero  = (sample_frame == 16'd0);
  assign one_key     = !frame_zero && ((sample_frame & (sample_frame - 16'd1)) == 16'd0);
  assign multi_key   = !frame_zero && !one_key;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_frame <= '0;
      stable_cnt <= '0;
    end else if (frame_close) begin
      if (frame_same) begin
        if (stable_cnt != CNT_FULL) begin
          stable_cnt <= stable_cnt + CNT_W'(1);
        end
      end else begin
        last_frame <= sample_frame;
        stable_cnt <= CNT_W'(1);
      end
    end
  end

  // Accepted when the post-update count is at the threshold.
  assign accept = frame_close &&
                  (frame_same ? (stable_cnt >= (CNT_FULL - CNT_W'(1))) : (DEBOUNCE_CNT == 1));

  always_comb begin
    key_index = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (sample_frame[i]) begin
        key_index = 4'(i);
      end
    end
  end

  // Press FSM with registered report outputs; a press must fully release before the next report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (one_key) begin
              key_code  <= key_index;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state     <= HELD;
            end else if (multi_key) begin
              state <= BLOCKED;
            end
          end
          HELD: begin
            if (frame_zero) begin
              key_held <= 1'b0;
              state    <= IDLE;
            end
          end
          BLOCKED: begin
            if (frame_zero) begin
              state <= IDLE;
            end
          end
          default: begin
            key_held <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

  assign kp.col       = col;
  assign kp.key_code  = key_code;
  assign kp.key_valid = key_valid;
  assign kp.key_held  = key_held;

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: a keypad model drives rows from a pressed-key mask; a frame-level
// reference model predicts col and the key report outputs every cycle.
module tb_key_scan;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 2;
  localparam int FRAME        = 4 * SCAN_DIV;

  localparam int M_IDLE    = 0;
  localparam int M_HELD    = 1;
  localparam int M_BLOCKED = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pressed;
  logic [3:0]  row_drive;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_last;
  int          m_cnt;
  int          m_state;
  logic [3:0]  m_code;
  logic        m_valid;

  key_scan_if kp ();

  key_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp.master)
  );

  always #5 clk = ~clk;

  // A closed key at (r, c) pulls row r high while column c is strobed.
  always_comb begin
    row_drive = '0;
    for (int r = 0; r < 4; r++) begin
      row_drive[r] = |(pressed[4*r +: 4] & kp.col);
    end
  end
  assign kp.row = row_drive;

  task automatic check_output(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_last  = '0;
    m_cnt   = 0;
    m_state = M_IDLE;
    m_code  = 4'd0;
    m_valid = 1'b0;
  endtask

  // Debounce and press rules applied to one complete keypad snapshot.
  task automatic model_frame(input logic [15:0] f);
    int n;
    m_valid = 1'b0;
    if (f == m_last) begin
      m_cnt = (m_cnt + 1 > DEBOUNCE_CNT) ? DEBOUNCE_CNT : m_cnt + 1;
    end else begin
      m_last = f;
      m_cnt  = 1;
    end
    if (m_cnt == DEBOUNCE_CNT) begin
      n = $countones(f);
      if (m_state == M_IDLE) begin
        if (n == 1) begin
          m_code  = 4'($clog2(f));
          m_valid = 1'b1;
          m_state = M_HELD;
        end else if (n > 1) begin
          m_state = M_BLOCKED;
        end
      end else if (n == 0) begin
        m_state = M_IDLE;
      end
    end
  endtask

  task automatic check_all(input logic [3:0] exp_col);
    check_output("col", kp.col, exp_col);
    check_output("key_valid", {3'b0, kp.key_valid}, {3'b0, m_valid});
    check_output("key_held", {3'b0, kp.key_held}, {3'b0, (m_state == M_HELD)});
    check_output("key_code", kp.key_code, m_code);
  endtask

  // Holds one key mask for a full frame, starting right after a frame boundary.
  task automatic apply_stimulus(input logic [15:0] mask);
    logic [3:0] one;
    one     = 4'b0001;
    pressed = mask;
    for (int k = 1; k <= FRAME; k++) begin
      @(posedge clk);
      #1;
      if (k == FRAME) begin
        model_frame(mask);
      end else begin
        m_valid = 1'b0;
      end
      check_all(one << ((k / SCAN_DIV) % 4));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all(4'b0001);
    @(posedge clk);
    #1;
    check_all(4'b0001);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] mask;
    int          kind;
    int          hold;

    pressed = '0;
    reset   = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all(4'b0001);
    reset = 1'b0;

    $display("[TB] idle frame and reset mid-run");
    apply_stimulus(16'h0000);
    repeat (7) @(posedge clk);
    #1;
    do_reset();

    $display("[TB] single press, key 9");
    repeat (3) apply_stimulus(16'h0001 << 9);
    repeat (2) apply_stimulus(16'h0000);

    $display("[TB] bounce on key 3");
    for (int i = 0; i < 6; i++) begin
      apply_stimulus((i % 2 == 0) ? (16'h0001 << 3) : 16'h0000);
    end
    repeat (2) apply_stimulus(16'h0001 << 3);
    repeat (2) apply_stimulus(16'h0000);

    $display("[TB] two keys 0 and 5");
    repeat (3) apply_stimulus(16'h0021);
    repeat (2) apply_stimulus(16'h0001);
    repeat (2) apply_stimulus(16'h0000);
    repeat (2) apply_stimulus(16'h0001);
    repeat (2) apply_stimulus(16'h0000);

    $display("[TB] roll-over 4 then 7");
    repeat (2) apply_stimulus(16'h0001 << 4);
    repeat (3) apply_stimulus(16'h0090);
    repeat (2) apply_stimulus(16'h0000);
    repeat (2) apply_stimulus(16'h0001 << 7);
    repeat (2) apply_stimulus(16'h0000);

    $display("[TB] reset while key 12 held");
    repeat (2) apply_stimulus(16'h0001 << 12);
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    repeat (2) apply_stimulus(16'h0001 << 12);
    repeat (2) apply_stimulus(16'h0000);

    $display("[TB] random presses");
    for (int s = 0; s < 40; s++) begin
      kind = int'($urandom_range(0, 3));
      mask = '0;
      if (kind == 1 || kind == 2) begin
        mask[$urandom_range(0, 15)] = 1'b1;
      end else if (kind == 3) begin
        mask[$urandom_range(0, 15)] = 1'b1;
        mask[$urandom_range(0, 15)] = 1'b1;
      end
      hold = int'($urandom_range(1, 3));
      repeat (hold) apply_stimulus(mask);
    end
    repeat (2) apply_stimulus(16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
